rol_serial: RTL

ROL_SERIAL -- requirements
Module: rol_serial

---
 rtl/rol_pkg.sv | 14 +
 rtl/rol_flag_gen.sv | 27 ++
 rtl/rol_serial.sv | 87 ++++++++
 3 files changed

// File: rtl/rol_pkg.sv
// Shared constants for the serial rotate-left unit.
// Holds the FSM state encoding and the [N,Z,C,V] flag bit positions.
package rol_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ROT  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    localparam int N_IDX = 3;
    localparam int Z_IDX = 2;
    localparam int C_IDX = 1;
    localparam int V_IDX = 0;

endpackage

// File: rtl/rol_flag_gen.sv
// Combinational flag generator for the rotate unit.
// Ports: result, rotated (k!=0), s (update enable), flag_in/flag_out [N,Z,C,V].
module rol_flag_gen
    import rol_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] result,
    input  logic              rotated,
    input  logic              s,
    input  logic [3:0]        flag_in,
    output logic [3:0]        flag_out
);

    always_comb begin
        flag_out = flag_in;
        if (s) begin
            flag_out[N_IDX] = result[DATA_W-1];
            flag_out[Z_IDX] = (result == '0);
            // A zero-amount rotate carries nothing out, so C is kept.
            if (rotated) begin
                flag_out[C_IDX] = result[0];
            end
        end
    end

endmodule

// File: rtl/rol_serial.sv
// Serial rotate-left: one bit position per cycle, then a done pulse.
// Ports: clk, rst, start, In1/In2 operands, S/Flag flag control;
//        busy, done, Result, New_Flag outputs.
module rol_serial
    import rol_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int AMT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] In1,
    input  logic [AMT_W-1:0]  In2,
    input  logic              S,
    input  logic [3:0]        Flag,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] Result,
    output logic [3:0]        New_Flag
);

    logic [1:0]        state;
    logic [AMT_W-1:0]  cnt;
    logic [AMT_W-1:0]  amt_q;
    logic [DATA_W-1:0] work;
    logic              s_q;
    logic [3:0]        flag_q;
    logic [3:0]        flag_nxt;

    rol_flag_gen #(
        .DATA_W (DATA_W)
    ) u_flag_gen (
        .result   (work),
        .rotated  (amt_q != '0),
        .s        (s_q),
        .flag_in  (flag_q),
        .flag_out (flag_nxt)
    );

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            amt_q    <= '0;
            work     <= '0;
            s_q      <= 1'b0;
            flag_q   <= 4'b0000;
            done     <= 1'b0;
            Result   <= '0;
            New_Flag <= 4'b0000;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        work   <= In1;
                        cnt    <= In2;
                        amt_q  <= In2;
                        s_q    <= S;
                        flag_q <= Flag;
                        state  <= (In2 != '0) ? ST_ROT : ST_FIN;
                    end
                end
                ST_ROT: begin
                    work <= {work[DATA_W-2:0], work[DATA_W-1]};
                    cnt  <= cnt - 1'b1;
                    if (cnt == AMT_W'(1)) begin
                        state <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    done     <= 1'b1;
                    Result   <= work;
                    New_Flag <= flag_nxt;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
